// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU adder result path.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] man;  // [24] carry, [23] hidden bit
  } fp_unnorm_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    EXC_NONE = 3'd0,
    EXC_QNAN = 3'd1,
    EXC_INF  = 3'd2,
    EXC_ZERO = 3'd3
  } exc_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_PACK,
    S_DONE
  } state_e;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even increment with no sticky bit; renormalises on carry-out.
module fpu_round_rne #(
  parameter int unsigned MAN_W = 25
) (
  input  logic [MAN_W-1:0] man,
  input  logic             guard,
  output logic [MAN_W-1:0] man_rnd,
  output logic             exp_inc
);

  logic [MAN_W-1:0] sum;

  always_comb begin
    sum     = man + {{(MAN_W-1){1'b0}}, guard & man[0]};
    exp_inc = sum[MAN_W-1];
    man_rnd = exp_inc ? (sum >> 1) : sum;
  end

endmodule

// File: rtl/fpu_norm_pack.sv
// Normalises an unnormalised FPU sum one bit per cycle, rounds RNE and packs an IEEE single.
module fpu_norm_pack
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 25
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [EXP_W+MAN_W:0] add_i,
  input  logic [2:0]         exception_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        result_o
);

  localparam logic [EXP_W:0] ExpOne = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] ExpSat = (EXP_W+1)'(EXP_MAX);

  fp_unnorm_t in_op;
  exc_e       exc;

  assign in_op = add_i;
  assign exc   = exc_e'(exception_i);

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [31:0]      result_q;
  logic             sign_q;
  logic [EXP_W:0]   exp_q;
  logic [MAN_W-1:0] man_q;
  logic             guard_q;

  logic [MAN_W-1:0] rnd_man;
  logic             rnd_exp_inc;
  logic [31:0]      exc_result;
  fp32_t            pack_result;

  fpu_round_rne #(
    .MAN_W(MAN_W)
  ) u_round (
    .man    (man_q),
    .guard  (guard_q),
    .man_rnd(rnd_man),
    .exp_inc(rnd_exp_inc)
  );

  always_comb begin
    case (exc)
      EXC_INF:  exc_result = {in_op.sign, EXP_MAX, 23'h0};
      EXC_ZERO: exc_result = {in_op.sign, 31'h0};
      default:  exc_result = QNAN;  // reserved codes collapse to QNAN
    endcase
  end

  always_comb begin
    pack_result.sign = sign_q;
    if (exp_q >= ExpSat) begin
      pack_result.exp  = EXP_MAX;
      pack_result.frac = '0;
    end else begin
      pack_result.exp  = exp_q[EXP_W-1:0];
      pack_result.frac = man_q[MAN_W-3:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      man_q       <= '0;
      guard_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            in_ready_q <= 1'b0;
            sign_q     <= in_op.sign;
            exp_q      <= (in_op.exp == '0) ? ExpOne : {1'b0, in_op.exp};
            man_q      <= in_op.man;
            guard_q    <= 1'b0;
            if (exc != EXC_NONE) begin
              result_q    <= exc_result;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (man_q == '0) begin
            sign_q  <= 1'b0;
            exp_q   <= '0;
            state_q <= S_PACK;
          end else if (man_q[MAN_W-1]) begin
            man_q   <= man_q >> 1;
            exp_q   <= exp_q + ExpOne;
            guard_q <= man_q[0];
            state_q <= S_ROUND;
          end else if (man_q[MAN_W-2]) begin
            state_q <= S_PACK;
          end else if (exp_q > ExpOne) begin
            man_q <= man_q << 1;
            exp_q <= exp_q - ExpOne;
          end else begin
            // Denormal: hidden bit still clear at the minimum exponent
            exp_q   <= '0;
            state_q <= S_PACK;
          end
        end
        S_ROUND: begin
          man_q <= rnd_man;
          if (rnd_exp_inc) exp_q <= exp_q + ExpOne;
          state_q <= S_PACK;
        end
        S_PACK: begin
          result_q    <= pack_result;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_fpu_norm_pack.sv
// Directed scoreboard bench for fpu_norm_pack: results, latency, handshake and reset.
module tb_fpu_norm_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] add;
  logic [2:0]  exc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  fpu_norm_pack u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .add_i      (add),
    .exception_i(exc),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Waits at negedges for out_valid; returns cycles counted from the accept edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run_op(input string tag, input logic [33:0] a, input logic [2:0] e,
                        input logic [31:0] expv, input int exp_lat);
    int lat;
    logic [31:0] want;
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    sb_q.push_back(expv);
    add = a;
    exc = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    want = sb_q.pop_front();
    check({tag, "_result"}, result, want);
    @(negedge clk);
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    rst = 1'b1;
    in_valid = 1'b0;
    add = '0;
    exc = 3'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'h0);

    run_op("one",       {1'b0, 8'd127, 25'h0800000}, 3'd0, 32'h3F80_0000, 3);
    run_op("carry",     {1'b0, 8'd127, 25'h1000000}, 3'd0, 32'h4000_0000, 4);
    run_op("tie_up",    {1'b0, 8'd127, 25'h1800003}, 3'd0, 32'h4040_0002, 4);
    run_op("tie_even",  {1'b0, 8'd127, 25'h1800001}, 3'd0, 32'h4040_0000, 4);
    run_op("shift23",   {1'b1, 8'd130, 25'h0000001}, 3'd0, 32'hB580_0000, 26);
    run_op("denorm",    {1'b0, 8'd1,   25'h0400000}, 3'd0, 32'h0040_0000, 3);
    run_op("exp0",      {1'b0, 8'd0,   25'h0800000}, 3'd0, 32'h0080_0000, 3);
    run_op("zero",      {1'b1, 8'd100, 25'h0000000}, 3'd0, 32'h0000_0000, 3);
    run_op("overflow",  {1'b0, 8'd254, 25'h1000000}, 3'd0, 32'h7F80_0000, 4);
    run_op("qnan",      {1'b0, 8'd3,   25'h0123456}, 3'd1, 32'h7FC0_0000, 1);
    run_op("inf",       {1'b1, 8'd3,   25'h0123456}, 3'd2, 32'hFF80_0000, 1);
    run_op("exc_zero",  {1'b1, 8'd9,   25'h0800000}, 3'd3, 32'h8000_0000, 1);
    run_op("reserved",  {1'b1, 8'd9,   25'h0800000}, 3'd6, 32'h7FC0_0000, 1);

    // Backpressure: result held while out_ready low, busy-time in_valid ignored
    out_ready = 1'b0;
    sb_q.push_back(32'h4000_0000);
    add = {1'b0, 8'd127, 25'h1000000};
    exc = 3'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd4);
    held = sb_q.pop_front();
    check("bp_result", result, held);
    for (int i = 0; i < 5; i++) begin
      add = {1'b0, 8'd10, 25'h0800000};
      exc = 3'd1;
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_result", result, held);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    exc = 3'd0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    run_op("after_bp", {1'b0, 8'd127, 25'h0800000}, 3'd0, 32'h3F80_0000, 3);

    // Reset in the middle of the long normalisation discards the operand
    add = {1'b1, 8'd130, 25'h0000001};
    exc = 3'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_result", result, 32'h0);
    repeat (30) @(negedge clk);
    check("mid_rst_no_output", 32'(out_valid), 32'd0);
    run_op("after_rst", {1'b0, 8'd127, 25'h0800000}, 3'd0, 32'h3F80_0000, 3);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
